// File: rtl/operand_entry.sv
// Keypad operand-entry controller: builds signed operands A and B from decimal key codes
// and hands the pair to the multiplier via operands_valid/op_ack. Backspace: OPERAND_ENTRY_BACKSPACE_EN.
module operand_entry #(
  parameter int WIDTH      = 8,
  parameter int MAX_DIGITS = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [3:0]                          key_value,
  input  logic                                key_pressed,
  input  logic                                op_ack,
  output logic [WIDTH-1:0]                    a_out,
  output logic [WIDTH-1:0]                    b_out,
  output logic                                operands_valid,
  output logic [WIDTH-2:0]                    disp_mag,
  output logic                                disp_neg,
  output logic [$clog2(MAX_DIGITS+1)-1:0]     digit_cnt,
  output logic                                entering_b,
  output logic                                entry_err
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int MW = WIDTH - 1;
  localparam int PW = WIDTH + 4;

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DIGITS);
  localparam logic [PW-1:0] MAX_MAG = {5'b0, {MW{1'b1}}};

  localparam logic [1:0] ST_ENTRY_A = 2'd0;
  localparam logic [1:0] ST_ENTRY_B = 2'd1;
  localparam logic [1:0] ST_READY   = 2'd2;

  localparam logic [3:0] KEY_STAR  = 4'hA;
  localparam logic [3:0] KEY_SIGN  = 4'hB;
  localparam logic [3:0] KEY_CLEAR = 4'hC;
  localparam logic [3:0] KEY_EQUAL = 4'hE;
`ifdef OPERAND_ENTRY_BACKSPACE_EN
  localparam logic [3:0] KEY_BKSP  = 4'hD;
`endif

  logic [1:0]       state_reg, state_next;
  logic [MW-1:0]    mag_reg, mag_next;
  logic             neg_reg, neg_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic             valid_reg, valid_next;
  logic             entb_reg, entb_next;
  logic             err_reg, err_next;
  logic             key_prev_reg;
  logic             key_armed_reg;

  logic             key_event;
  logic [PW-1:0]    mag_ext;
  logic [PW-1:0]    cand;
  logic             digit_ok;
  logic [WIDTH-1:0] mag_w;
  logic [WIDTH-1:0] commit_val;

  // Armed only after key_pressed has been seen low, so a key held through reset is ignored.
  assign key_event = key_pressed & ~key_prev_reg & key_armed_reg;

  // Candidate magnitude is kept wide enough that mag*10+d cannot wrap before the range test.
  assign mag_ext  = {5'b0, mag_reg};
  assign cand     = (mag_ext << 3) + (mag_ext << 1) + {{(PW-4){1'b0}}, key_value};
  assign digit_ok = (cnt_reg < MAX_CNT) && (cand <= MAX_MAG);

  assign mag_w      = {1'b0, mag_reg};
  assign commit_val = neg_reg ? ({WIDTH{1'b0}} - mag_w) : mag_w;

`ifdef OPERAND_ENTRY_BACKSPACE_EN
  logic [MW-1:0] mag_div10;
  assign mag_div10 = MW'(mag_ext / PW'(10));
`endif

  always_comb begin
    state_next = state_reg;
    mag_next   = mag_reg;
    neg_next   = neg_reg;
    cnt_next   = cnt_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    valid_next = valid_reg;
    err_next   = 1'b0;

    if (key_event && key_value == KEY_CLEAR) begin
      state_next = ST_ENTRY_A;
      mag_next   = '0;
      neg_next   = 1'b0;
      cnt_next   = '0;
      a_next     = '0;
      b_next     = '0;
      valid_next = 1'b0;
    end else if (state_reg == ST_READY) begin
      // Keys other than clear are silently dropped while the pair waits for the multiplier.
      if (op_ack) begin
        state_next = ST_ENTRY_A;
        valid_next = 1'b0;
        mag_next   = '0;
        neg_next   = 1'b0;
        cnt_next   = '0;
      end
    end else if (key_event) begin
      if (key_value <= 4'd9) begin
        if (digit_ok) begin
          mag_next = cand[MW-1:0];
          cnt_next = cnt_reg + CW'(1);
        end else begin
          err_next = 1'b1;
        end
      end else begin
        case (key_value)
          KEY_STAR: begin
            if (state_reg == ST_ENTRY_A) begin
              a_next     = commit_val;
              mag_next   = '0;
              neg_next   = 1'b0;
              cnt_next   = '0;
              state_next = ST_ENTRY_B;
            end else begin
              err_next = 1'b1;
            end
          end
          KEY_SIGN: neg_next = ~neg_reg;
          KEY_EQUAL: begin
            if (state_reg == ST_ENTRY_B) begin
              b_next     = commit_val;
              mag_next   = '0;
              neg_next   = 1'b0;
              cnt_next   = '0;
              valid_next = 1'b1;
              state_next = ST_READY;
            end else begin
              err_next = 1'b1;
            end
          end
`ifdef OPERAND_ENTRY_BACKSPACE_EN
          KEY_BKSP: begin
            if (cnt_reg != '0) begin
              mag_next = mag_div10;
              cnt_next = cnt_reg - CW'(1);
            end else begin
              err_next = 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
    end

    entb_next = (state_next == ST_ENTRY_B);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_ENTRY_A;
      mag_reg       <= '0;
      neg_reg       <= 1'b0;
      cnt_reg       <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      valid_reg     <= 1'b0;
      entb_reg      <= 1'b0;
      err_reg       <= 1'b0;
      key_prev_reg  <= 1'b0;
      key_armed_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mag_reg       <= mag_next;
      neg_reg       <= neg_next;
      cnt_reg       <= cnt_next;
      a_reg         <= a_next;
      b_reg         <= b_next;
      valid_reg     <= valid_next;
      entb_reg      <= entb_next;
      err_reg       <= err_next;
      key_prev_reg  <= key_pressed;
      key_armed_reg <= key_armed_reg | ~key_pressed;
    end
  end

  assign a_out          = a_reg;
  assign b_out          = b_reg;
  assign operands_valid = valid_reg;
  assign disp_mag       = mag_reg;
  assign disp_neg       = neg_reg;
  assign digit_cnt      = cnt_reg;
  assign entering_b     = entb_reg;
  assign entry_err      = err_reg;

endmodule

// File: tb/tb_operand_entry.sv
// Scoreboard bench for operand_entry (WIDTH=8, MAX_DIGITS=3): a behavioural model pushes the
// expected output snapshot for every driven cycle and it is popped and compared after the edge.
module tb_operand_entry;

  localparam int WIDTH      = 8;
  localparam int MAX_DIGITS = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] key_value = 4'h7;
  logic       key_pressed = 1'b1;
  logic       op_ack = 1'b0;
  logic [7:0] a_out, b_out;
  logic       operands_valid;
  logic [6:0] disp_mag;
  logic       disp_neg;
  logic [1:0] digit_cnt;
  logic       entering_b;
  logic       entry_err;

  operand_entry #(.WIDTH(WIDTH), .MAX_DIGITS(MAX_DIGITS)) dut (
    .clk(clk), .rst(rst), .key_value(key_value), .key_pressed(key_pressed), .op_ack(op_ack),
    .a_out(a_out), .b_out(b_out), .operands_valid(operands_valid), .disp_mag(disp_mag),
    .disp_neg(disp_neg), .digit_cnt(digit_cnt), .entering_b(entering_b), .entry_err(entry_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       valid;
    logic [6:0] mag;
    logic       neg;
    logic [1:0] cnt;
    logic       entb;
    logic       err;
  } snap_t;

  snap_t sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: 0 = ENTRY_A, 1 = ENTRY_B, 2 = READY
  int         m_state, m_mag, m_cnt;
  bit         m_neg, m_valid, m_prev, m_armed, m_err;
  logic [7:0] m_a, m_b;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_mag = 0; m_cnt = 0; m_neg = 0; m_valid = 0;
    m_prev = 0; m_armed = 0; m_err = 0; m_a = 8'h00; m_b = 8'h00;
  endtask

  task automatic zero_entry();
    m_mag = 0; m_cnt = 0; m_neg = 0;
  endtask

  task automatic push_expected();
    snap_t s;
    s.a = m_a; s.b = m_b; s.valid = m_valid; s.mag = 7'(m_mag); s.neg = m_neg;
    s.cnt = 2'(m_cnt); s.entb = (m_state == 1); s.err = m_err;
    sb_q.push_back(s);
  endtask

  task automatic model_step(input bit kp, input logic [3:0] kv, input bit ack);
    bit ev;
    ev = kp && !m_prev && m_armed;
    m_prev = kp;
    if (!kp) m_armed = 1;
    m_err = 0;
    if (ev && kv == 4'hC) begin
      zero_entry(); m_a = 8'h00; m_b = 8'h00; m_valid = 0; m_state = 0;
    end else if (m_state == 2) begin
      if (ack) begin m_valid = 0; zero_entry(); m_state = 0; end
    end else if (ev) begin
      if (kv <= 4'd9) begin
        if (m_cnt < MAX_DIGITS && m_mag * 10 + int'(kv) <= 127) begin
          m_mag = m_mag * 10 + int'(kv);
          m_cnt++;
        end else m_err = 1;
      end else if (kv == 4'hA) begin
        if (m_state == 0) begin
          m_a = m_neg ? 8'(-m_mag) : 8'(m_mag); zero_entry(); m_state = 1;
        end else m_err = 1;
      end else if (kv == 4'hB) begin
        m_neg = !m_neg;
      end else if (kv == 4'hE) begin
        if (m_state == 1) begin
          m_b = m_neg ? 8'(-m_mag) : 8'(m_mag); zero_entry(); m_valid = 1; m_state = 2;
        end else m_err = 1;
      end
`ifdef OPERAND_ENTRY_BACKSPACE_EN
      else if (kv == 4'hD) begin
        if (m_cnt > 0) begin m_mag = m_mag / 10; m_cnt--; end
        else m_err = 1;
      end
`endif
    end
    push_expected();
  endtask

  task automatic compare_pop(input string tag);
    snap_t e;
    if (sb_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s.scoreboard: observed empty queue expected an entry", tag);
      return;
    end
    e = sb_q.pop_front();
    check_eq({tag, ".a_out"},          32'(a_out),          32'(e.a));
    check_eq({tag, ".b_out"},          32'(b_out),          32'(e.b));
    check_eq({tag, ".operands_valid"}, 32'(operands_valid), 32'(e.valid));
    check_eq({tag, ".disp_mag"},       32'(disp_mag),       32'(e.mag));
    check_eq({tag, ".disp_neg"},       32'(disp_neg),       32'(e.neg));
    check_eq({tag, ".digit_cnt"},      32'(digit_cnt),      32'(e.cnt));
    check_eq({tag, ".entering_b"},     32'(entering_b),     32'(e.entb));
    check_eq({tag, ".entry_err"},      32'(entry_err),      32'(e.err));
  endtask

  // Called at posedge+1: drives inputs, predicts, and checks the outputs after the next edge.
  task automatic drive_cycle(input bit kp, input logic [3:0] kv, input bit ack, input string tag);
    key_pressed = kp; key_value = kv; op_ack = ack;
    model_step(kp, kv, ack);
    @(posedge clk); #1;
    compare_pop(tag);
  endtask

  task automatic press(input logic [3:0] k);
    string tag;
    tag = $sformatf("key_%h", k);
    drive_cycle(1'b1, k, 1'b0, tag);
    $display("key 0x%h: a=%h b=%h valid=%b mag=%0d neg=%b cnt=%0d entb=%b err=%b",
             k, a_out, b_out, operands_valid, disp_mag, disp_neg, digit_cnt, entering_b, entry_err);
    drive_cycle(1'b0, k, 1'b0, {tag, "_rel"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    push_expected();
    compare_pop("reset");
    @(negedge clk);
    rst = 1'b1;

    // Key held through reset release: no event until released and pressed again
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 4'h7, 1'b0, "held_thru_rst");
    drive_cycle(1'b0, 4'h7, 1'b0, "release");
    check_eq("held_thru_rst.cnt", 32'(digit_cnt), 32'd0);

    // 125 * -3
    press(4'h1); press(4'h2); press(4'h5); press(4'hA);
    press(4'hB); press(4'h3); press(4'hE);
    check_eq("tp1.a_out", 32'(a_out), 32'h7D);
    check_eq("tp1.b_out", 32'(b_out), 32'hFD);
    check_eq("tp1.valid", 32'(operands_valid), 32'd1);
    press(4'h5);
    drive_cycle(1'b0, 4'hF, 1'b1, "ack");
    check_eq("tp1.ack_valid", 32'(operands_valid), 32'd0);
    check_eq("tp1.ack_entb", 32'(entering_b), 32'd0);
    check_eq("tp1.ack_a_hold", 32'(a_out), 32'h7D);
    check_eq("tp1.ack_b_hold", 32'(b_out), 32'hFD);
    drive_cycle(1'b0, 4'hF, 1'b0, "idle");

    // Range limit and digit-count limit
    press(4'h1); press(4'h2); press(4'h8);
    check_eq("tp2.mag12", 32'(disp_mag), 32'd12);
    check_eq("tp2.cnt2", 32'(digit_cnt), 32'd2);
    press(4'hC);
    press(4'h9); press(4'h9); press(4'h9); press(4'h9);
    check_eq("tp2.mag99", 32'(disp_mag), 32'd99);
    press(4'hC);
    press(4'h1); press(4'h0); press(4'h0); press(4'h1);
    check_eq("cnt_limit.mag", 32'(disp_mag), 32'd100);
    press(4'hC);

    // Held key yields a single event
    for (int i = 0; i < 20; i++) drive_cycle(1'b1, 4'h7, 1'b0, "hold7");
    drive_cycle(1'b0, 4'h7, 1'b0, "hold7_rel");
    check_eq("tp3.mag", 32'(disp_mag), 32'd7);
    check_eq("tp3.cnt", 32'(digit_cnt), 32'd1);
    press(4'hC);

    // Backspace
    press(4'h4); press(4'h5); press(4'hD);
`ifdef OPERAND_ENTRY_BACKSPACE_EN
    check_eq("tp4.bksp", 32'(disp_mag), 32'd4);
`else
    check_eq("tp4.bksp", 32'(disp_mag), 32'd45);
`endif
    press(4'hB); press(4'hD); press(4'hD);
    press(4'hF);
    press(4'hC);

    // Misplaced commit keys, clear from ENTRY_B, op_ack outside READY
    press(4'hE);
    press(4'h6); press(4'hA);
    check_eq("tp5.a6", 32'(a_out), 32'd6);
    press(4'hA);
    drive_cycle(1'b0, 4'hF, 1'b1, "ack_in_b");
    drive_cycle(1'b0, 4'hF, 1'b0, "idle");
    press(4'hC);
    check_eq("tp5.clr_a", 32'(a_out), 32'd0);
    check_eq("tp5.clr_entb", 32'(entering_b), 32'd0);

    // Negative zero commits as 0
    press(4'hB); press(4'hA); press(4'hB); press(4'hE);
    check_eq("neg0.a", 32'(a_out), 32'd0);
    check_eq("neg0.b", 32'(b_out), 32'd0);
    drive_cycle(1'b0, 4'hF, 1'b1, "ack_neg0");
    drive_cycle(1'b0, 4'hF, 1'b0, "idle");

    // Clear and op_ack in the same cycle
    press(4'h2); press(4'hA); press(4'h7); press(4'hE);
    drive_cycle(1'b1, 4'hC, 1'b1, "clr_ack");
    drive_cycle(1'b0, 4'hC, 1'b0, "clr_ack_rel");
    check_eq("tp6.a", 32'(a_out), 32'd0);
    check_eq("tp6.b", 32'(b_out), 32'd0);
    check_eq("tp6.valid", 32'(operands_valid), 32'd0);
    check_eq("tp6.entb", 32'(entering_b), 32'd0);

    // Asynchronous reset mid-entry
    press(4'h1); press(4'hA); press(4'hB); press(4'h4);
    rst = 1'b0;
    #2;
    model_reset();
    push_expected();
    compare_pop("async_rst");
    check_eq("async_rst.a", 32'(a_out), 32'd0);
    check_eq("async_rst.mag", 32'(disp_mag), 32'd0);
    #2;
    rst = 1'b1;
    drive_cycle(1'b0, 4'hF, 1'b0, "post_rst");
    press(4'h3);
    check_eq("post_rst.mag", 32'(disp_mag), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_entry.md
# operand_entry

Keypad operand-entry controller for the Booth multiplier datapath. It converts a stream of decoded 4-bit keypad codes into two signed two's-complement operands, A and B, each `WIDTH` bits wide. It provides a live display value while digits are entered and hands the operand pair to the multiplier through a valid/ack handshake. It sits between the keypad decoder and the multiplier core, and adds range checking, per-operand sign entry and clear to the earlier fixed 8-bit storage.

## Interface
- `WIDTH`, 8: operand width in bits, two's complement; minimum 4.
- `MAX_DIGITS`, 3: maximum decimal digits accepted per operand; minimum 1.
- `clk  in  1`: clock, rising edge.
- `rst  in  1`: reset, asynchronous, active-low.
- `key_value  in  4`: decoded key code. 0x0–0x9 digit, 0xA `*` (commit A), 0xB sign toggle, 0xC clear, 0xD backspace, 0xE `=` (commit B), 0xF no-op.
- `key_pressed  in  1`: level from the debouncer. Only its rising edge is acted on.
- `op_ack  in  1`: one-cycle pulse from the multiplier; it consumes the current operand pair.
- `a_out  out  WIDTH`: committed operand A, signed.
- `b_out  out  WIDTH`: committed operand B, signed.
- `operands_valid  out  1`: high while the A/B pair awaits `op_ack`.
- `disp_mag  out  WIDTH-1`: magnitude of the entry in progress.
- `disp_neg  out  1`: sign of the entry in progress.
- `digit_cnt  out  $clog2(MAX_DIGITS+1)`: digits currently entered.
- `entering_b  out  1`: high in state ENTRY_B.
- `entry_err  out  1`: one-cycle pulse when a key is rejected.

## Operation
- FSM states: ENTRY_A (reset state), ENTRY_B, READY.
- Key event: `key_pressed`=1 and its registered previous value = 0. A held key produces exactly one event.
- Digit d, in ENTRY_A or ENTRY_B:
  - Accepted only if `digit_cnt` < `MAX_DIGITS` and `mag*10 + d` ≤ 2^(WIDTH-1)−1.
  - On accept: `mag` ← `mag*10 + d` and `digit_cnt` increments.
  - Otherwise `mag` is unchanged and `entry_err` pulses.
  - `mag*10 + d` is computed in at least WIDTH+4 bits so the range check never wraps.
- Sign toggle (0xB), in ENTRY_A or ENTRY_B: inverts `disp_neg`. Allowed at any digit count, including zero.
- `*` (0xA):
  - In ENTRY_A: `a_out` ← `disp_neg` ? −mag : mag. The entry (`mag`, sign, count) is zeroed and the FSM goes to ENTRY_B.
  - In any other state the key is ignored and `entry_err` pulses.
- `=` (0xE):
  - In ENTRY_B: `b_out` is loaded the same way as `a_out`, the entry is zeroed, `operands_valid` ← 1 and the FSM goes to READY.
  - In any other state the key is ignored and `entry_err` pulses.
- Committing with zero digits entered gives 0. The result is always 0, never −0 artefacts.
- READY:
  - All keys except clear are ignored, with no `entry_err`.
  - `op_ack` clears `operands_valid`, zeroes the entry and returns the FSM to ENTRY_A.
  - `a_out` and `b_out` hold their values after `op_ack`.
- Clear (0xC), from any state: zeroes the entry, `a_out`, `b_out` and `operands_valid`; the FSM goes to ENTRY_A.
- Simultaneous clear key event and `op_ack`: clear wins.
- `op_ack` outside READY is ignored.
- 0xF is always ignored.

## Timing
- All outputs are registered.
- Reset value of every output is 0, and the FSM resets to ENTRY_A. Reset also clears the key-edge register, so a key held through reset deassertion generates no event until it is released and pressed again.
- Key latency: a key event sampled at edge n is reflected on every output after edge n.
- `operands_valid` rises after the same edge that samples `=`. It falls after the edge that samples `op_ack`.
- Minimum key spacing: two events need `key_pressed` low for at least one sampled cycle between them.
- Reset mid-entry or in READY abandons all state immediately, asynchronously.

## Configuration
- Macro: `OPERAND_ENTRY_BACKSPACE_EN`.
- When defined, 0xD in ENTRY_A/ENTRY_B does the following:
  - If `digit_cnt` > 0: `mag` ← floor(mag/10) and `digit_cnt` decrements. The sign is kept.
  - If `digit_cnt` = 0: `entry_err` pulses.
- When not defined, 0xD is ignored like 0xF, and no divider logic is synthesised.

## Test plan
All scenarios use WIDTH=8 and MAX_DIGITS=3.

- Keys 1,2,5,`*`,0xB,3,`=` -> `a_out`=0x7D, `b_out`=0xFD, `operands_valid`=1, FSM in READY. Then `op_ack` pulse -> `operands_valid`=0, `entering_b`=0, `a_out`/`b_out` unchanged.
- Keys 1,2,8 -> `disp_mag`=12 and `digit_cnt`=2 after the 8 key, and `entry_err` pulses once. Keys 9,9,9,9 -> `disp_mag`=99 and `entry_err` pulses on the third 9 and on the fourth 9.
- `key_pressed` held high for 20 cycles with `key_value`=7 -> `disp_mag`=7 and `digit_cnt`=1.
- Keys 4,5,0xD -> `disp_mag`=4 with the macro defined, 45 without it. Then 0xD,0xD with the macro -> 0 after the first, and `entry_err` on the second.
- Keys `=` in ENTRY_A -> `entry_err` pulses and no state change. Keys 6,`*`,0xC in ENTRY_B -> `a_out`=0 and FSM in ENTRY_A. `rst` low mid-entry -> all outputs 0 asynchronously.
- In READY, clear key event and `op_ack` on the same cycle -> FSM in ENTRY_A, `a_out`=`b_out`=0, `operands_valid`=0.
